spike_rle_encoder: RTL
======================

// Module: spike_rle_encoder
// PURPOSE
//   Downstream consumer of the LIF/MVM neuron's 1-bit spike output.
//   Run-length encodes the sparse spike train into 8-bit events: silent timesteps are counted, not transmitted.
//   Events are buffered in a small FIFO and drained over a valid/ready port that feeds the 8-bit uio_out bus.
//   Event format: bit7 = kind, bits[6:0] = gap.
//     - kind 0: gap silent steps, then a spike.
//     - kind 1: gap silent steps, no spike.
// PARAMETERS
//   GAP_W   7   width of the gap counter and of the event payload; event width = GAP_W+1
//   DEPTH   4   FIFO entries; power of 2, >= 2
// PORTS
//   clk          in   1        clock; all logic on rising edge
//   rst          in   1        synchronous, active-high reset
//   en           in   1        timestep strobe; spike is sampled only when en=1
//   spike        in   1        spike from neuron for the current timestep
//   flush        in   1        end-of-window; emit any pending silent run
//   out_data     out  GAP_W+1  head-of-FIFO event
//   out_valid    out  1        FIFO not empty
//   out_ready    in   1        consumer accepts out_data when out_valid=1
//   fifo_level   out  $clog2(DEPTH)+1  entries currently held
//   overflow     out  1        sticky: an event was dropped on a full FIFO
// BEHAVIOUR
//   Reset
//     - gap=0, FIFO empty, out_valid=0, out_data=0, fifo_level=0, overflow=0.
//     - Applies mid-operation: the pending gap and all buffered events are discarded.
//   Gap counter (gap, GAP_W bits); all cases assume en=1. Rows are listed with flush=0 first, then flush=1.
//     - en & spike, flush=0: push {0,gap}; gap<=0.
//     - en & !spike, flush=0:
//         - g1=gap+1.
//         - If g1==2^GAP_W-1 (127): push {1,127}, gap<=0 (saturation token).
//         - Otherwise gap<=g1; no push.
//     - en & spike, flush=1: push {0,gap}; gap<=0. No second event.
//     - en & !spike, flush=1: push {1,g1}; gap<=0.
//     - !en & flush: if gap!=0, push {1,gap}, gap<=0. If gap==0, no push.
//     - !en & !flush: hold.
//     - At most one push per cycle.
//   FIFO: first-word-fall-through with registered storage
//     - A push in cycle N is visible on out_data with out_valid=1 in cycle N+1 when the FIFO was empty.
//     - Latency from strobe to output is 1 cycle.
//     - pop = out_valid & out_ready. out_data advances to the next entry in the following cycle.
//     - Push and pop in the same cycle: both take effect and level is unchanged. This is legal when full.
//     - Push while full with no pop: the event is dropped and overflow<=1 until rst. gap still resets to 0.
//     - Pop while empty: ignored.
//     - out_data is undefined-but-stable (holds the last value) when out_valid=0.
//     - Pointers wrap modulo DEPTH.
//     - fifo_level is always in the range 0..DEPTH.
//   Consumer reconstruction: the sum of (gap + kind0?1:0) over all events equals the number of en strobes since the last flush.
// STRUCTURE
//   - spike_pkg
//       - localparams KIND_SPIKE=1'b0, KIND_SILENT=1'b1
//       - default GAP_W, DEPTH
//       - function make_event(kind, gap)
//   - Sub-module sync_fifo: parameterised WIDTH/DEPTH, FWFT, with full, empty and level.
//   - Encoder FSM-free: the gap counter plus push-decode logic lives in this file.
// TESTING
//   1. Spike train 0,0,0,1 on 4 en strobes, out_ready=1 -> one event 8'h03 at cycle 5, out_valid for 1 cycle.
//   2. 127 strobes with spike=0 -> event 8'hFF on the 127th strobe; gap restarts at 0; the next spike emits 8'h00.
//   3. Spikes on 6 consecutive strobes, out_ready=0, DEPTH=4 -> fifo_level=4; overflow=1 after the 5th push;
//      draining yields four 8'h00 events.
//   4. 5 silent strobes, then flush with en=0 -> event 8'h85.
//      Repeat the flush immediately -> no event (gap==0).
//   5. Full FIFO, out_ready=1, and a spike in the same cycle -> level stays 4, overflow stays 0,
//      event order is preserved.
//   6. rst asserted with 3 queued events and gap=9 -> next cycle out_valid=0, level=0, overflow=0;
//      the first spike after rst emits 8'h00.

Source files
------------

// File: rtl/spike_pkg.sv
// Shared constants and event packing for the spike run-length encoder.
// Event layout: kind in the MSB, silent-step count in the low bits.
package spike_pkg;

  localparam int DEFAULT_GAP_W = 7;
  localparam int DEFAULT_DEPTH = 4;

  localparam logic KIND_SPIKE  = 1'b0;
  localparam logic KIND_SILENT = 1'b1;

  function automatic logic [DEFAULT_GAP_W:0] make_event(
    input logic                     kind,
    input logic [DEFAULT_GAP_W-1:0] gap
  );
    return {kind, gap};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with registered storage and an occupancy count.
// The head word is read straight from storage, so a push shows up one cycle later.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // When empty, keep showing the most recently popped word so the bus stays stable.
  assign pop_data = empty ? mem[rd_ptr - AW'(1)] : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spike_rle_encoder.sv
// Run-length encoder for a 1-bit spike train: counts silent timesteps and emits
// one event per spike, per saturated run, or per flushed run, into a small FIFO.
module spike_rle_encoder
  import spike_pkg::*;
#(
  parameter int GAP_W = DEFAULT_GAP_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     spike,
  input  logic                     flush,
  output logic [GAP_W:0]           out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam logic [GAP_W-1:0] GAP_MAX = '1;

  logic [GAP_W-1:0] gap;
  logic [GAP_W-1:0] gap_inc;
  logic [GAP_W-1:0] next_gap;
  logic [GAP_W-1:0] push_gap;
  logic             push_kind;
  logic             push;
  logic [GAP_W:0]   push_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  assign gap_inc = gap + GAP_W'(1);

  // A run that would reach the all-ones count is closed out as a silent token
  // so the counter never wraps; a flush on a silent strobe includes that strobe.
  always_comb begin
    push      = 1'b0;
    push_kind = KIND_SPIKE;
    push_gap  = gap;
    next_gap  = gap;
    if (en) begin
      if (spike) begin
        push     = 1'b1;
        next_gap = '0;
      end else if (flush || gap_inc == GAP_MAX) begin
        push      = 1'b1;
        push_kind = KIND_SILENT;
        push_gap  = gap_inc;
        next_gap  = '0;
      end else begin
        next_gap = gap_inc;
      end
    end else if (flush && gap != '0) begin
      push      = 1'b1;
      push_kind = KIND_SILENT;
      next_gap  = '0;
    end
  end

  generate
    if (GAP_W == DEFAULT_GAP_W) begin : g_pack_default
      assign push_data = make_event(push_kind, push_gap);
    end else begin : g_pack_generic
      assign push_data = {push_kind, push_gap};
    end
  endgenerate

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      gap      <= '0;
      overflow <= 1'b0;
    end else begin
      gap <= next_gap;
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (GAP_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

endmodule
